// File: rtl/sblk_row_disp.sv
// Row instruction dispatcher. A single masked instruction stream fills per-row FIFOs, and one
// issue/ack/run handshake FSM per row drains each FIFO. Optional watchdog: SBLK_ROW_DISP_WDOG_EN.

module sblk_row_disp #(
    parameter int N_ROW      = 3,
    parameter int WID_INST   = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int WID_CNT    = 16,
    parameter int WID_WDOG   = 8
) (
    input  logic                      clk_h,
    input  logic                      rst,
    input  logic [WID_INST-1:0]       in_inst_data,
    input  logic [N_ROW-1:0]          in_inst_mask,
    input  logic                      in_inst_vld,
    output logic                      in_inst_rdy,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic [N_ROW-1:0]          row_busy,
    output logic                      all_idle,
    output logic [WID_CNT-1:0]        done_cnt,
    output logic [N_ROW-1:0]          err_wdog,
    input  logic                      err_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_RUN
    } state_e;

    state_e                    state_q [N_ROW];
    state_e                    state_d [N_ROW];
    logic [WID_INST-1:0]       mem_q   [N_ROW][FIFO_DEPTH];
    logic [PW-1:0]             wptr_q  [N_ROW];
    logic [PW-1:0]             wptr_d  [N_ROW];
    logic [PW-1:0]             rptr_q  [N_ROW];
    logic [PW-1:0]             rptr_d  [N_ROW];
    logic [CW-1:0]             cnt_q   [N_ROW];
    logic [CW-1:0]             cnt_d   [N_ROW];
    logic [WID_INST*N_ROW-1:0] inst_data_q, inst_data_d;
    logic [N_ROW-1:0]          inst_en_q, inst_en_d;
    logic [WID_CNT-1:0]        done_q, done_d, done_inc;
    logic [N_ROW-1:0]          full, empty, push, pop, cmpl, tmo, wdog_hit;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            full[r]  = (cnt_q[r] == CW'(FIFO_DEPTH));
            empty[r] = (cnt_q[r] == '0);
        end
    end

    // Readiness looks at the registered fill level only, so a pop in this cycle never
    // frees space for a push in the same cycle.
    assign in_inst_rdy = &(~in_inst_mask | ~full);
    assign push        = in_inst_mask & {N_ROW{in_inst_vld & in_inst_rdy}};

    always_comb begin
        pop  = '0;
        cmpl = '0;
        tmo  = '0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            state_d[r] = state_q[r];
            case (state_q[r])
                S_IDLE: begin
                    if (!empty[r] && !status_sblk[r]) begin
                        pop[r]     = 1'b1;
                        state_d[r] = S_ISSUE;
                    end
                end
                S_ISSUE: state_d[r] = S_ACK;
                S_ACK: begin
                    if (status_sblk[r]) begin
                        state_d[r] = S_RUN;
                    end else if (wdog_hit[r]) begin
                        tmo[r]     = 1'b1;
                        state_d[r] = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (!status_sblk[r]) begin
                        cmpl[r]    = 1'b1;
                        state_d[r] = S_IDLE;
                    end else if (wdog_hit[r]) begin
                        tmo[r]     = 1'b1;
                        state_d[r] = S_IDLE;
                    end
                end
                default: state_d[r] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        inst_data_d = inst_data_q;
        inst_en_d   = pop;
        done_inc    = '0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            wptr_d[r] = push[r] ? wptr_q[r] + PW'(1) : wptr_q[r];
            rptr_d[r] = pop[r]  ? rptr_q[r] + PW'(1) : rptr_q[r];
            cnt_d[r]  = cnt_q[r];
            if (push[r] && !pop[r]) begin
                cnt_d[r] = cnt_q[r] + CW'(1);
            end else if (!push[r] && pop[r]) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
            if (pop[r]) begin
                inst_data_d[r*WID_INST +: WID_INST] = mem_q[r][rptr_q[r]];
            end
            done_inc = done_inc + WID_CNT'(cmpl[r]);
        end
        done_d = done_q + done_inc;
    end

    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < N_ROW; r++) begin
                state_q[r] <= S_IDLE;
                wptr_q[r]  <= '0;
                rptr_q[r]  <= '0;
                cnt_q[r]   <= '0;
            end
            inst_data_q <= '0;
            inst_en_q   <= '0;
            done_q      <= '0;
        end else begin
            for (int unsigned r = 0; r < N_ROW; r++) begin
                state_q[r] <= state_d[r];
                wptr_q[r]  <= wptr_d[r];
                rptr_q[r]  <= rptr_d[r];
                cnt_q[r]   <= cnt_d[r];
            end
            inst_data_q <= inst_data_d;
            inst_en_q   <= inst_en_d;
            done_q      <= done_d;
        end
    end

    // Storage needs no reset: pointers and counts alone define which entries are live.
    always_ff @(posedge clk_h) begin
        for (int unsigned r = 0; r < N_ROW; r++) begin
            if (push[r]) begin
                mem_q[r][wptr_q[r]] <= in_inst_data;
            end
        end
    end

    always_comb begin
        row_busy = '0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            row_busy[r] = (state_q[r] != S_IDLE);
        end
    end

    assign all_idle  = ~(|row_busy) & (&empty);
    assign inst_data = inst_data_q;
    assign inst_en   = inst_en_q;
    assign done_cnt  = done_q;

`ifdef SBLK_ROW_DISP_WDOG_EN
    localparam logic [WID_WDOG-1:0] WDOG_LAST = {{(WID_WDOG-1){1'b1}}, 1'b0};

    logic [WID_WDOG-1:0] wdog_q [N_ROW];
    logic [WID_WDOG-1:0] wdog_d [N_ROW];
    logic [N_ROW-1:0]    err_q, err_d;

    // Hit is flagged one count early so the error lands on the edge the counter reaches all-ones.
    always_comb begin
        wdog_hit = '0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            wdog_hit[r] = ((state_q[r] == S_ACK) || (state_q[r] == S_RUN)) && (wdog_q[r] == WDOG_LAST);
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < N_ROW; r++) begin
            if (pop[r]) begin
                wdog_d[r] = '0;
            end else if ((state_q[r] == S_ACK) || (state_q[r] == S_RUN)) begin
                wdog_d[r] = wdog_q[r] + WID_WDOG'(1);
            end else begin
                wdog_d[r] = wdog_q[r];
            end
        end
        err_d = (err_q & ~{N_ROW{err_clr}}) | tmo;
    end

    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < N_ROW; r++) begin
                wdog_q[r] <= '0;
            end
            err_q <= '0;
        end else begin
            for (int unsigned r = 0; r < N_ROW; r++) begin
                wdog_q[r] <= wdog_d[r];
            end
            err_q <= err_d;
        end
    end

    assign err_wdog = err_q;
`else
    logic [WID_WDOG:0] unused_wdog;

    assign wdog_hit    = '0;
    assign err_wdog    = '0;
    assign unused_wdog = {WID_WDOG'(0), err_clr | (|tmo)};
`endif

endmodule

// File: tb/tb_sblk_row_disp.sv
// Scoreboard bench for sblk_row_disp: per-row expected-issue queues filled on accept, a
// monitor that checks every inst_en strobe, and a behavioural superblock responder per row.

module tb_sblk_row_disp;

    localparam int NR    = 3;
    localparam int WI    = 14;
    localparam int DEPTH = 4;
    localparam int WC    = 16;
    localparam int WW    = 8;

    logic              clk_h = 1'b0;
    logic              rst   = 1'b0;
    logic [WI-1:0]     in_inst_data = '0;
    logic [NR-1:0]     in_inst_mask = '0;
    logic              in_inst_vld  = 1'b0;
    logic              in_inst_rdy;
    logic [WI*NR-1:0]  inst_data;
    logic [NR-1:0]     inst_en;
    logic [NR-1:0]     status_sblk = '0;
    logic [NR-1:0]     row_busy;
    logic              all_idle;
    logic [WC-1:0]     done_cnt;
    logic [NR-1:0]     err_wdog;
    logic              err_clr = 1'b0;

    sblk_row_disp #(
        .N_ROW      (NR),
        .WID_INST   (WI),
        .FIFO_DEPTH (DEPTH),
        .WID_CNT    (WC),
        .WID_WDOG   (WW)
    ) dut (
        .clk_h        (clk_h),
        .rst          (rst),
        .in_inst_data (in_inst_data),
        .in_inst_mask (in_inst_mask),
        .in_inst_vld  (in_inst_vld),
        .in_inst_rdy  (in_inst_rdy),
        .inst_data    (inst_data),
        .inst_en      (inst_en),
        .status_sblk  (status_sblk),
        .row_busy     (row_busy),
        .all_idle     (all_idle),
        .done_cnt     (done_cnt),
        .err_wdog     (err_wdog),
        .err_clr      (err_clr)
    );

    always #5 clk_h = ~clk_h;

    logic [WI-1:0] exp_q [NR][$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            model_done = 0;
    logic [NR-1:0] busy = '0;
    logic [NR-1:0] hold_busy = '0;
    logic [NR-1:0] resp_off = '0;
    int            rs [NR];
    int            rd [NR];
    int            rw [NR];
    int            force_w = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Monitor: every issue strobe must match the oldest outstanding instruction of that row.
    initial begin
        logic [WI-1:0] e;
        forever begin
            @(negedge clk_h);
            for (int r = 0; r < NR; r++) begin
                if (inst_en[r] === 1'b1) begin
                    if (exp_q[r].size() == 0) begin
                        n_chk++;
                        $display("FAIL spurious_issue_row%0d: actual inst_en=1 required 0", r);
                    end else begin
                        e = exp_q[r].pop_front();
                        chk($sformatf("issue_data_row%0d", r), inst_data[r*WI +: WI], e);
                    end
                end
            end
        end
    end

    // Superblock responder: after an issue, rises busy after a short delay, holds it, then drops it.
    initial begin
        for (int r = 0; r < NR; r++) begin
            rs[r] = 0; rd[r] = 0; rw[r] = 0;
        end
        forever begin
            @(negedge clk_h);
            for (int r = 0; r < NR; r++) begin
                case (rs[r])
                    0: if (inst_en[r] === 1'b1 && !resp_off[r]) begin
                        rd[r] = (force_w > 0) ? 0 : $urandom_range(0, 2);
                        rw[r] = (force_w > 0) ? force_w : $urandom_range(1, 5);
                        rs[r] = 1;
                    end
                    1: if (rd[r] == 0) begin
                        busy[r] = 1'b1;
                        rs[r]   = 2;
                    end else begin
                        rd[r]--;
                    end
                    default: begin
                        rw[r]--;
                        if (rw[r] == 0) begin
                            busy[r] = 1'b0;
                            rs[r]   = 0;
                            model_done++;
                        end
                    end
                endcase
            end
            status_sblk = busy | hold_busy;
        end
    end

    // Called at posedge+1; returns at posedge+1 so consecutive calls can be back-to-back.
    task automatic push(input logic [WI-1:0] d, input logic [NR-1:0] m, input int tries, output bit acc);
        logic exp_rdy;
        logic rdy_s;
        acc = 1'b0;
        in_inst_data = d;
        in_inst_mask = m;
        in_inst_vld  = 1'b1;
        for (int i = 0; i < tries && !acc; i++) begin
            @(negedge clk_h); #1;
            exp_rdy = 1'b1;
            for (int r = 0; r < NR; r++) begin
                if (m[r] && exp_q[r].size() >= DEPTH) exp_rdy = 1'b0;
            end
            chk("in_inst_rdy", in_inst_rdy, exp_rdy);
            rdy_s = in_inst_rdy;
            @(posedge clk_h);
            if (rdy_s) begin
                for (int r = 0; r < NR; r++) begin
                    if (m[r]) exp_q[r].push_back(d);
                end
                acc = 1'b1;
            end
        end
        #1;
        in_inst_vld = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk_h); #1;
            ok = 1'b1;
            for (int r = 0; r < NR; r++) begin
                if (exp_q[r].size() != 0 || rs[r] != 0) ok = 1'b0;
            end
        end
        if (!ok) fail({tag, "_drain"});
        repeat (3) @(negedge clk_h);
        chk({tag, "_done_cnt"}, done_cnt, 64'(model_done[15:0]));
        chk({tag, "_all_idle"}, all_idle, 1);
        chk({tag, "_row_busy"}, row_busy, 0);
        chk({tag, "_err_wdog"}, err_wdog, 0);
        @(posedge clk_h); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_inst_data"}, inst_data, 0);
        chk({tag, "_inst_en"}, inst_en, 0);
        chk({tag, "_row_busy"}, row_busy, 0);
        chk({tag, "_done_cnt"}, done_cnt, 0);
        chk({tag, "_err_wdog"}, err_wdog, 0);
        chk({tag, "_all_idle"}, all_idle, 1);
        chk({tag, "_rdy"}, in_inst_rdy, 1);
    endtask

    initial begin
        #500000;
        fail("global_time_limit");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        bit acc;
        int base;
        logic [WI-1:0] d;
        logic [NR-1:0] m;
        bit seen;

        #1 rst = 1'b1;
        in_inst_mask = 3'b111;
        repeat (2) @(negedge clk_h);
        chk_reset_vals("reset");
        @(posedge clk_h); #1;
        rst = 1'b0;
        in_inst_mask = '0;
        @(negedge clk_h);
        chk("rdy_after_reset", in_inst_rdy, 1);
        @(posedge clk_h); #1;

        // Unicast: issue strobe two cycles after the accepting edge, one cycle wide.
        force_w = 5;
        push(14'h0123, 3'b010, 5, acc);
        chk("uni_accept", acc, 1);
        @(negedge clk_h); chk("uni_en_t1", inst_en, 3'b000);
        @(negedge clk_h); chk("uni_en_t2", inst_en, 3'b010);
        chk("uni_data", inst_data[WI +: WI], 14'h0123);
        @(negedge clk_h); chk("uni_en_t3", inst_en, 3'b000);
        @(posedge clk_h); #1;
        drain("uni");
        chk("uni_done_one", done_cnt, 1);

        // Broadcast with simultaneous completion.
        force_w = 3;
        base = model_done;
        push(14'h2a5c, 3'b111, 5, acc);
        chk("bc_accept", acc, 1);
        @(negedge clk_h);
        @(negedge clk_h); chk("bc_en", inst_en, 3'b111);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_h);
            if (done_cnt != 16'(base)) seen = 1'b1;
        end
        if (!seen) fail("bc_done_wait");
        else chk("bc_done_step", 16'(done_cnt - 16'(base)), 3);
        @(posedge clk_h); #1;
        drain("bc");
        force_w = 0;

        // Backpressure on row 0.
        hold_busy[0] = 1'b1;
        status_sblk  = status_sblk | 3'b001;
        for (int k = 0; k < DEPTH; k++) begin
            push(14'h0100 + 14'(k), 3'b001, 1, acc);
            chk("bp_fill_accept", acc, 1);
        end
        push(14'h3fff, 3'b011, 1, acc);
        chk("bp_stall_011", acc, 0);
        push(14'h3ffe, 3'b001, 1, acc);
        chk("bp_stall_001", acc, 0);
        push(14'h0a0a, 3'b010, 1, acc);
        chk("bp_pass_010", acc, 1);
        hold_busy[0] = 1'b0;
        drain("bp");

        // Randomized traffic, including zero masks.
        for (int n = 0; n < 200; n++) begin
            d = WI'($urandom);
            m = NR'($urandom_range(0, 7));
            push(d, m, 200, acc);
            if (!acc) fail("rnd_accept");
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_h); #1;
            end
        end
        drain("rnd");

        // Counter wrap.
        force dut.done_q = 16'hFFFF;
        @(posedge clk_h); #1;
        release dut.done_q;
        model_done = 65535;
        @(negedge clk_h);
        chk("wrap_preload", done_cnt, 16'hFFFF);
        @(posedge clk_h); #1;
        push(14'h1111, 3'b100, 5, acc);
        drain("wrap");
        chk("wrap_zero", done_cnt, 0);

`ifdef SBLK_ROW_DISP_WDOG_EN
        // Watchdog: row 0 issued but its superblock never goes busy.
        resp_off[0] = 1'b1;
        base = model_done;
        push(14'h0bad, 3'b001, 5, acc);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_h);
            if (inst_en[0] === 1'b1) seen = 1'b1;
        end
        if (!seen) fail("wdog_issue_wait");
        repeat ((1 << WW) - 1) @(negedge clk_h);
        chk("wdog_not_yet", err_wdog[0], 0);
        @(negedge clk_h);
        chk("wdog_err", err_wdog[0], 1);
        chk("wdog_row_idle", row_busy[0], 0);
        chk("wdog_done_same", done_cnt, 64'(base[15:0]));
        @(posedge clk_h); #1;
        err_clr = 1'b1;
        @(posedge clk_h); #1;
        err_clr = 1'b0;
        @(negedge clk_h);
        chk("wdog_clr", err_wdog, 0);
        resp_off[0] = 1'b0;
        @(posedge clk_h); #1;
`endif

        // Reset while row 2 is running with two more queued.
        force_w = 30;
        for (int k = 0; k < 3; k++) begin
            push(14'h2200 + 14'(k), 3'b100, 5, acc);
            chk("rst_fill_accept", acc, 1);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_h);
            if (exp_q[2].size() == 2) seen = 1'b1;
        end
        if (!seen) fail("rst_issue_wait");
        repeat (4) @(negedge clk_h);
        chk("pre_rst_busy", row_busy[2], 1);
        @(posedge clk_h); #1;
        rst = 1'b1;
        in_inst_mask = 3'b111;
        for (int r = 0; r < NR; r++) begin
            exp_q[r].delete();
            rs[r] = 0;
        end
        busy = '0;
        status_sblk = '0;
        model_done = 0;
        force_w = 0;
        @(negedge clk_h);
        chk_reset_vals("midrst");
        @(posedge clk_h); #1;
        rst = 1'b0;
        in_inst_mask = '0;
        repeat (10) @(negedge clk_h);
        chk("post_rst_all_idle", all_idle, 1);
        chk("post_rst_done", done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sblk_row_disp.md
# sblk_row_disp

Instruction dispatcher for a row of N_ROW superblocks. It accepts one instruction stream tagged with a row mask and buffers each instruction in a per-row FIFO; broadcast to several rows is allowed. Each row gets its own handshake FSM, which issues `inst_en` pulses only when that superblock reports idle and tracks the busy/idle cycle to completion. The block sits between the top-level controller and the `sblk` row array, and drives their `inst_data`/`inst_en` and consumes `status_sblk`.

## Interface
- `N_ROW`, 3, number of superblock rows served.
- `WID_INST`, 14, instruction width (TN+TM+TP+LN+LP fields, opaque here).
- `FIFO_DEPTH`, 4, per-row instruction FIFO depth, power of two, ≥2.
- `WID_CNT`, 16, completion counter width.
- `WID_WDOG`, 8, watchdog counter width (used only with `SBLK_ROW_DISP_WDOG_EN`).

Ports (clock and reset first):
- `clk_h`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_inst_data`  in  WID_INST  instruction payload.
- `in_inst_mask`  in  N_ROW  target rows; bit r set means deliver to row r.
- `in_inst_vld`  in  1  upstream valid.
- `in_inst_rdy`  out  1  upstream ready (combinational).
- `inst_data`  out  WID_INST*N_ROW  per-row instruction; row r occupies `[r*WID_INST +: WID_INST]`; registered.
- `inst_en`  out  N_ROW  per-row one-cycle issue strobe; registered.
- `status_sblk`  in  N_ROW  per-row busy flag from the superblock (1 = busy).
- `row_busy`  out  N_ROW  1 while the row FSM is not IDLE.
- `all_idle`  out  1  all FSMs IDLE and all FIFOs empty.
- `done_cnt`  out  WID_CNT  count of completed instructions, summed over rows.
- `err_wdog`  out  N_ROW  sticky watchdog error per row.
- `err_clr`  in  1  clears `err_wdog`; ignored without the macro.

## Operation
- **Accept.** `in_inst_rdy` = AND over r of (`!in_inst_mask[r]` | `!full[r]`). The rdy decision uses the current `full` only; a same-cycle pop does not free space.
- **Transfer.** On `vld & rdy`, push the payload into every masked FIFO in the same cycle. This is all-or-nothing, so broadcast is atomic. A zero mask is accepted and dropped.
- **Row FSM states:** IDLE, ISSUE, ACK, RUN.
- **IDLE → ISSUE** when the FIFO is non-empty and `status_sblk[r]==0`. On this edge the FIFO head is popped and loaded into `inst_data[r]`, and `inst_en[r]` is set.
- **ISSUE → ACK** unconditionally after one cycle. `inst_en[r]` is high for exactly this cycle.
- **ACK → RUN** when `status_sblk[r]==1`.
- **RUN → IDLE** when `status_sblk[r]==0`. That edge is a completion.
- **`inst_data[r]` hold.** It keeps the last issued value until the next issue.
- **`done_cnt`.** Adds the popcount of the completions in each cycle, so simultaneous completions on several rows all count. It wraps modulo 2^WID_CNT.
- **FIFO.** Push and pop may occur on the same FIFO in the same cycle (not-full case); occupancy is unchanged. FIFO order is strictly preserved per row.
- **Reset.** A reset, including one asserted mid-operation, empties all FIFOs, sends every FSM to IDLE, and clears all counters and errors.

## Timing
- **Reset values:** `inst_data`=0, `inst_en`=0, `row_busy`=0, `done_cnt`=0, `err_wdog`=0, `all_idle`=1. `in_inst_rdy`=1 during and after reset.
- **Issue latency.** A push at edge t, into an empty FIFO of an idle row with `status_sblk[r]`=0, makes the FIFO non-empty after t. `inst_en[r]` is high in the cycle after edge t+1.
- **Back-to-back issue.** The minimum spacing between issues to one row is 4 cycles (ISSUE, ACK, RUN, IDLE), assuming `status_sblk` rises 1 cycle after `inst_en` and falls 1 cycle later.
- **Other outputs.** `row_busy` and `all_idle` are decoded from registered state and carry no input-to-output combinational path.
- **Combinational path.** `in_inst_rdy` is the only combinational output, and it depends on `in_inst_mask` and `full`.

## Configuration
- **`SBLK_ROW_DISP_WDOG_EN` defined:**
  - A per-row WID_WDOG counter runs in ACK and RUN and resets on entering ISSUE.
  - On reaching 2^WID_WDOG−1, it sets `err_wdog[r]` (sticky) and the FSM returns to IDLE with no completion counted.
  - `err_clr` clears all `err_wdog` bits on the next edge. If a new timeout occurs in the same cycle, the set wins.
- **`SBLK_ROW_DISP_WDOG_EN` undefined:** there is no watchdog logic. `err_wdog` is tied to 0, `err_clr` is unused, and ACK/RUN wait indefinitely.

## Test plan
- **Unicast.** Mask=3'b010, data=14'h0123 with `status_sblk` idle gives `inst_en`=3'b010 for one cycle, 2 cycles after the push edge, with `inst_data[1]`=14'h0123. After a busy pulse of 5 cycles, `done_cnt`=1.
- **Broadcast and simultaneous completion.** Mask=3'b111 with all rows idle gives all three `inst_en` high in the same cycle. With all busy flags dropping together, `done_cnt` goes 0→3 on a single edge.
- **Full/backpressure.** Hold row 0 busy and push 4 instructions with mask=3'b001; `in_inst_rdy` then drops. A 5th with mask=3'b011 stalls, while a 5th with mask=3'b010 is accepted. After row 0 drains, all issue in order.
- **Wrap.** Preload `done_cnt` to 16'hFFFF via 65535 completions, or by force; one more completion gives 16'h0000.
- **Reset mid-operation.** Assert `rst` while row 2 is in RUN with 2 queued instructions. All outputs return to reset values, and after release no `inst_en` fires.
- **Watchdog (macro on, WID_WDOG=4).** Issue to row 0 and never assert `status_sblk[0]`. `err_wdog[0]`=1 after 15 cycles in ACK, the row returns to IDLE, and `done_cnt` is unchanged. `err_clr` then sets `err_wdog`=0.
